// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Requester side of a word-addressed, combinational-read instruction memory.
// Owns the fetch PC, drives the byte address, captures the returned word into
// a small prefetch FIFO and presents {pc, instr} to decode over valid/ready.
// Branch/jump redirects flush every prefetched word and restart fetching at
// the (word-aligned) target.
//
// Optional feature macro: IFU_ALIGN_CHECK_EN
//   When defined, a misaligned redirect target halts the unit and raises a
//   sticky align_fault output instead of silently clearing bits [1:0].
//
// Ports:
//   clk            in   1           rising-edge clock
//   rst_n          in   1           asynchronous active-low reset
//   fetch_en       in   1           leave IDLE and start fetching
//   imem_addr      out  ADDR_WIDTH  byte address to instruction memory
//   imem_dout      in   DATA_WIDTH  word at imem_addr (same cycle)
//   redirect_valid in   1           one-cycle branch/jump request
//   redirect_pc    in   ADDR_WIDTH  redirect target byte address
//   inst_valid     out  1           FIFO head holds an instruction
//   inst_ready     in   1           decode accepts the head
//   inst_data      out  DATA_WIDTH  head instruction
//   inst_pc        out  ADDR_WIDTH  head instruction address
//   halted         out  1           fetch FSM is in HALT
//   align_fault    out  1           sticky misaligned-redirect flag
//                                   (only with IFU_ALIGN_CHECK_EN)
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 100,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_dout,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  halted
`ifdef IFU_ALIGN_CHECK_EN
    ,
    output logic                  align_fault
`endif
);

    localparam int unsigned           PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned           CNT_W   = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'((MEM_DEPTH - 1) * 4);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    // S_START is a one-cycle priming step between IDLE and RUN so the first
    // word is fetched in the second cycle after fetch_en is sampled.
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_HALT
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
`ifdef IFU_ALIGN_CHECK_EN
    logic                  r_align_fault;
    logic                  w_misaligned;
`endif

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_redir_tgt;
    logic                  w_tgt_in_range;
    logic                  w_redir_take;
    logic                  w_push;

    assign w_valid        = (r_count != '0);
    assign w_pop          = w_valid & inst_ready;
    // A full FIFO still has room when the head leaves in the same cycle.
    assign w_room         = (r_count < CNT_W'(FIFO_DEPTH)) | w_pop;
    assign w_in_range     = (r_fetch_pc <= LAST_PC);
    assign w_redir_tgt    = redirect_pc & WORD_MASK;
    assign w_tgt_in_range = (w_redir_tgt <= LAST_PC);

`ifdef IFU_ALIGN_CHECK_EN
    assign w_misaligned   = (redirect_pc[1:0] != 2'b00);
    assign w_redir_take   = redirect_valid & (r_state != S_IDLE) & ~r_align_fault;
`else
    assign w_redir_take   = redirect_valid & (r_state != S_IDLE);
`endif

    // A redirect wins over the push of the word fetched in the same cycle.
    assign w_push = (r_state == S_RUN) & w_in_range & w_room & ~w_redir_take;

    // ------------------------------------------------------------------
    // FSM, fetch PC and FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
`ifdef IFU_ALIGN_CHECK_EN
            r_align_fault <= 1'b0;
`endif
        end else if (w_redir_take) begin
            // Flush; a handshake in this cycle has already been seen by
            // decode, so discarding the head with the rest is correct.
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
`ifdef IFU_ALIGN_CHECK_EN
            if (w_misaligned) begin
                r_state       <= S_HALT;
                r_align_fault <= 1'b1;
            end else
`endif
            begin
                r_fetch_pc <= w_redir_tgt;
                r_state    <= w_tgt_in_range ? S_RUN : S_HALT;
            end
        end else begin
            case (r_state)
                S_IDLE:  if (fetch_en) r_state <= S_START;
                S_START: r_state <= S_RUN;
                S_RUN:   if (!w_in_range) r_state <= S_HALT;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase

            if (w_push) begin
                r_wptr     <= r_wptr + PTR_W'(1);
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents are qualified by r_count, so no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]   <= r_fetch_pc;
            r_fifo_data[r_wptr] <= imem_dout;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = w_valid;
    // Head fields read as zero when empty so reset leaves them at 0.
    assign inst_data  = w_valid ? r_fifo_data[r_rptr] : '0;
    assign inst_pc    = w_valid ? r_fifo_pc[r_rptr]   : '0;
    assign halted     = (r_state == S_HALT);
`ifdef IFU_ALIGN_CHECK_EN
    assign align_fault = r_align_fault;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. Two instances share all control
// inputs: dut_a uses MEM_DEPTH=100, dut_b uses MEM_DEPTH=4 for the
// end-of-memory scenario. Each has its own memory model returning
// 0x1000 + word index. Outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic [31:0] a_addr, a_dout, a_data, a_pc;
    logic        a_valid, a_halted;
    logic [31:0] b_addr, b_dout, b_data, b_pc;
    logic        b_valid, b_halted;
`ifdef IFU_ALIGN_CHECK_EN
    logic        a_fault, b_fault;
`endif

    int unsigned n_tests;
    int unsigned n_fail;

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (100),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (a_addr),
        .imem_dout      (a_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (a_valid),
        .inst_ready     (inst_ready),
        .inst_data      (a_data),
        .inst_pc        (a_pc),
        .halted         (a_halted)
`ifdef IFU_ALIGN_CHECK_EN
        ,
        .align_fault    (a_fault)
`endif
    );

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (4),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (b_addr),
        .imem_dout      (b_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (b_valid),
        .inst_ready     (inst_ready),
        .inst_data      (b_data),
        .inst_pc        (b_pc),
        .halted         (b_halted)
`ifdef IFU_ALIGN_CHECK_EN
        ,
        .align_fault    (b_fault)
`endif
    );

    // Memory model: word i holds 0x1000 + i
    assign a_dout = 32'h1000 + (a_addr >> 2);
    assign b_dout = 32'h1000 + (b_addr >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // Reset, then start fetching; returns with the first head (pc 0) visible.
    task automatic start_run(input logic ready);
        do_reset();
        inst_ready = ready;
        fetch_en   = 1'b1;
        tick(3);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // ---------------- reset state and IDLE redirect ----------------
        do_reset();
        check("rst_valid",  64'(a_valid),  64'd0);
        check("rst_data",   64'(a_data),   64'd0);
        check("rst_pc",     64'(a_pc),     64'd0);
        check("rst_halted", 64'(a_halted), 64'd0);
        check("rst_addr",   64'(a_addr),   64'd0);
`ifdef IFU_ALIGN_CHECK_EN
        check("rst_fault",  64'(a_fault),  64'd0);
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick(1);
        redirect_valid = 1'b0;
        tick(2);
        check("idle_redir_addr",  64'(a_addr),  64'd0);
        check("idle_redir_valid", 64'(a_valid), 64'd0);

        // ---------------- sequential fetch ----------------
        start_run(1'b1);
        for (int i = 0; i < 6; i++) begin
            check("seq_valid", 64'(a_valid), 64'd1);
            check("seq_pc",    64'(a_pc),    64'(i * 4));
            check("seq_data",  64'(a_data),  64'(32'h1000 + i));
            tick(1);
        end

        // ---------------- backpressure ----------------
        start_run(1'b0);
        check("bp_first_pc", 64'(a_pc), 64'h0);
        tick(4);
        check("bp_hold_valid", 64'(a_valid), 64'd1);
        check("bp_hold_pc",    64'(a_pc),    64'h0);
        check("bp_hold_data",  64'(a_data),  64'h1000);
        check("bp_fetch_stop", 64'(a_addr),  64'h8);
        inst_ready = 1'b1;
        tick(1);
        check("bp_resume_pc0", 64'(a_pc),   64'h4);
        check("bp_resume_d0",  64'(a_data), 64'h1001);
        tick(1);
        check("bp_resume_pc1", 64'(a_pc),   64'h8);
        tick(1);
        check("bp_resume_pc2", 64'(a_pc),   64'hC);

        // ---------------- redirect flush ----------------
        start_run(1'b1);
        tick(2);
        check("rd_head8", 64'(a_pc), 64'h8);
        inst_ready = 1'b0;
        tick(1);
        check("rd_full_head", 64'(a_pc),   64'h8);
        check("rd_full_addr", 64'(a_addr), 64'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick(1);
        redirect_valid = 1'b0;
        check("rd_flush_valid", 64'(a_valid), 64'd0);
        check("rd_flush_addr",  64'(a_addr),  64'h40);
        inst_ready = 1'b1;
        tick(1);
        check("rd_tgt_valid", 64'(a_valid), 64'd1);
        check("rd_tgt_pc",    64'(a_pc),    64'h40);
        check("rd_tgt_data",  64'(a_data),  64'h1010);
        tick(1);
        check("rd_next_pc",   64'(a_pc),    64'h44);

`ifndef IFU_ALIGN_CHECK_EN
        // Misaligned target: low bits cleared silently
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4E;
        tick(1);
        redirect_valid = 1'b0;
        check("mis_addr", 64'(a_addr), 64'h4C);
        tick(1);
        check("mis_pc",   64'(a_pc),   64'h4C);
`endif

        // ---------------- end of memory (dut_b, MEM_DEPTH=4) ----------------
        start_run(1'b1);
        for (int i = 0; i < 4; i++) begin
            check("eom_pc",     64'(b_pc),     64'(i * 4));
            check("eom_halted", 64'(b_halted), 64'd0);
            tick(1);
        end
        check("eom_valid_off", 64'(b_valid),  64'd0);
        check("eom_halted_on", 64'(b_halted), 64'd1);
        tick(2);
        check("eom_stay_halt", 64'(b_halted), 64'd1);
        check("eom_stay_inv",  64'(b_valid),  64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick(1);
        redirect_valid = 1'b0;
        check("eom_resume_run", 64'(b_halted), 64'd0);
        tick(1);
        check("eom_resume_pc",  64'(b_pc),    64'h0);
        check("eom_resume_vld", 64'(b_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick(1);
        redirect_valid = 1'b0;
        check("eom_oor_halt",  64'(b_halted), 64'd1);
        check("eom_oor_empty", 64'(b_valid),  64'd0);

        // ---------------- reset mid-run ----------------
        start_run(1'b0);
        tick(1);
        check("mr_full_valid", 64'(a_valid), 64'd1);
        rst_n    = 1'b0;
        fetch_en = 1'b0;
        #1;
        check("mr_async_valid", 64'(a_valid), 64'd0);
        check("mr_async_addr",  64'(a_addr),  64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(4);
        check("mr_idle_valid", 64'(a_valid), 64'd0);
        check("mr_idle_addr",  64'(a_addr),  64'd0);
        inst_ready = 1'b1;
        fetch_en   = 1'b1;
        tick(2);
        check("mr_latency", 64'(a_valid), 64'd0);
        tick(1);
        check("mr_first_pc",   64'(a_pc),   64'h0);
        check("mr_first_data", 64'(a_data), 64'h1000);

`ifdef IFU_ALIGN_CHECK_EN
        // ---------------- alignment fault ----------------
        start_run(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick(1);
        redirect_valid = 1'b0;
        check("al_fault",  64'(a_fault),  64'd1);
        check("al_halted", 64'(a_halted), 64'd1);
        check("al_valid",  64'(a_valid),  64'd0);
        check("al_addr",   64'(a_addr),   64'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick(1);
        redirect_valid = 1'b0;
        tick(2);
        check("al_ign_halt",  64'(a_halted), 64'd1);
        check("al_ign_addr",  64'(a_addr),   64'h4);
        check("al_ign_valid", 64'(a_valid),  64'd0);
        check("al_sticky",    64'(a_fault),  64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
